// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered log2 stage per shift-amount bit, valid/ready with global stall.
// Define SHIFT_ROTATE_EN to make op 11 a rotate right; otherwise op 11 behaves as a logical right shift.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 5,
    localparam int SAW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SAW-1:0]   in_sa,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    // Fixed-distance shift used by a single stage; the distance is a per-stage constant.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       op,
                                                     input int               amt);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = $signed(d) >>> amt;
`ifdef SHIFT_ROTATE_EN
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`endif
            default: r = d >> amt;
        endcase
        return r;
    endfunction

    logic [SAW-1:0]   valid_q, valid_d, src_valid;
    logic [WIDTH-1:0] data_q  [SAW];
    logic [WIDTH-1:0] data_d  [SAW];
    logic [WIDTH-1:0] src_data[SAW];
    logic [TAG_W-1:0] tag_q   [SAW];
    logic [TAG_W-1:0] tag_d   [SAW];
    logic [TAG_W-1:0] src_tag [SAW];
    logic [1:0]       src_op  [SAW];
    logic [SAW-1:0]   src_sa  [SAW];
    // The output stage needs no op/sa, so only SAW-1 of these are registered.
    logic [1:0]       op_q    [SAW-1];
    logic [1:0]       op_d    [SAW-1];
    logic [SAW-1:0]   sa_q    [SAW-1];
    logic [SAW-1:0]   sa_d    [SAW-1];
    logic             advance;

    assign advance   = !valid_q[SAW-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[SAW-1];
    assign out_data  = data_q[SAW-1];
    assign out_tag   = tag_q[SAW-1];
    assign busy      = |valid_q;

    assign src_valid   = {valid_q[SAW-2:0], in_valid};
    assign src_data[0] = in_data;
    assign src_tag[0]  = in_tag;
    assign src_op[0]   = in_op;
    assign src_sa[0]   = in_sa;

    for (genvar k = 1; k < SAW; k++) begin : g_link
        assign src_data[k] = data_q[k-1];
        assign src_tag[k]  = tag_q[k-1];
        assign src_op[k]   = op_q[k-1];
        assign src_sa[k]   = sa_q[k-1];
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < SAW; k++) begin
            data_d[k] = data_q[k];
            tag_d[k]  = tag_q[k];
        end
        for (int k = 0; k < SAW - 1; k++) begin
            op_d[k] = op_q[k];
            sa_d[k] = sa_q[k];
        end
        // Global stall: every stage moves together or none does, so bubbles stay in place.
        if (advance) begin
            valid_d = src_valid;
            for (int k = 0; k < SAW; k++) begin
                data_d[k] = src_sa[k][k] ? stage_shift(src_data[k], src_op[k], 1 << k) : src_data[k];
                tag_d[k]  = src_tag[k];
            end
            for (int k = 0; k < SAW - 1; k++) begin
                op_d[k] = src_op[k];
                sa_d[k] = src_sa[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < SAW; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            for (int k = 0; k < SAW - 1; k++) begin
                op_q[k] <= '0;
                sa_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < SAW; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
            for (int k = 0; k < SAW - 1; k++) begin
                op_q[k] <= op_d[k];
                sa_q[k] <= sa_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=16, TAG_W=5) against a whole-word shift model.
// Honours SHIFT_ROTATE_EN the same way as the design build.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 16;
    localparam int TAG_W = 5;
    localparam int SAW   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] t;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SAW-1:0]   in_sa;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sa     (in_sa),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-word reference: the full shift amount applied at once.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [1:0] op, input int sa);
        logic [2*WIDTH-1:0] dd;
        case (op)
            2'd0: return d << sa;
            2'd1: return d >> sa;
            2'd2: return $signed(d) >>> sa;
            default: begin
`ifdef SHIFT_ROTATE_EN
                dd = {d, d} >> sa;
                return dd[WIDTH-1:0];
`else
                dd = {{WIDTH{1'b0}}, d} >> sa;
                return dd[WIDTH-1:0];
`endif
            end
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        checks++;
        if (out_data !== 16'h0000 || out_tag !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: out_data=%h out_tag=%0d required 0000 0", out_data, out_tag);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0001; in_sa = 4'd15; in_op = 2'd0; in_tag = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_edge1: out_valid=%b busy=%b required 0 1", out_valid, busy);
        end
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency_early edge %0d: out_valid=%b required 0", i, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_tag !== 5'd3) begin
            errors++;
            $display("[TB] FAIL latency_result: valid=%b data=%h tag=%0d required 1 8000 3",
                     out_valid, out_data, out_tag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_single_cycle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_arith();
        logic [WIDTH-1:0] d  [5];
        logic [1:0]       op [5];
        logic [SAW-1:0]   sa [5];
        logic [WIDTH-1:0] ex [5];
        int n;
        d[0] = 16'h8000; op[0] = 2'd2; sa[0] = 4'd4; ex[0] = 16'hF800;
        d[1] = 16'h8000; op[1] = 2'd1; sa[1] = 4'd4; ex[1] = 16'h0800;
        d[2] = 16'hFFFF; op[2] = 2'd0; sa[2] = 4'd0; ex[2] = 16'hFFFF;
        d[3] = 16'h1234; op[3] = 2'd3; sa[3] = 4'd4;
`ifdef SHIFT_ROTATE_EN
        ex[3] = 16'h4123;
`else
        ex[3] = 16'h0123;
`endif
        d[4] = 16'hA5C3; op[4] = 2'd2; sa[4] = 4'd0; ex[4] = 16'hA5C3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = d[i]; in_op = op[i]; in_sa = sa[i]; in_tag = 5'(i + 8);
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL arith_timeout vector %0d: no out_valid within 10 cycles", i);
            end else if (out_data !== ex[i] || out_tag !== 5'(i + 8)) begin
                errors++;
                $display("[TB] FAIL arith vector %0d: data=%h tag=%0d required %h %0d",
                         i, out_data, out_tag, ex[i], i + 8);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic [WIDTH-1:0] held_d;
        logic [TAG_W-1:0] held_t;
        int got;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'($urandom); in_op = 2'($urandom); in_sa = 4'($urandom);
            in_tag = 5'(i);
            q.push_back({model(in_data, in_op, int'(in_sa)), in_tag});
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_accept op %0d: in_ready=%b required 1", i, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
            errors++;
            $display("[TB] FAIL b2b_first: valid=%b tag=%0d required 1 1", out_valid, out_tag);
        end
        held_d = out_data;
        held_t = out_tag;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
                errors++;
                $display("[TB] FAIL b2b_stall cycle %0d: in_ready=%b valid=%b data=%h tag=%0d required 0 1 %h %0d",
                         c, in_ready, out_valid, out_data, out_tag, held_d, held_t);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (out_valid) begin
                e = q.pop_front();
                checks++;
                if (out_data !== e.d || out_tag !== e.t) begin
                    errors++;
                    $display("[TB] FAIL b2b_order result %0d: data=%h tag=%0d required %h %0d",
                             got, out_data, out_tag, e.d, e.t);
                end
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results required 4", got);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_duplicate: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_inflight();
        logic stale;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'hFFFF; in_op = 2'd0; in_sa = 4'd0; in_tag = 5'(20 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inflight_pre: out_valid=%b busy=%b required 1 1", out_valid, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000 || out_tag !== 5'd0) begin
            errors++;
            $display("[TB] FAIL inflight_reset: valid=%b busy=%b data=%h tag=%0d required 0 0 0000 0",
                     out_valid, busy, out_data, out_tag);
        end
        @(negedge clk);
        reset = 1'b0;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inflight_stale: stale result seen=%b required 0", stale);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic             prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_d = '0;
        logic [TAG_W-1:0] prev_t = '0;
        int n;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_op     = 2'($urandom);
            in_sa     = 4'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("[TB] FAIL rand_in_ready cycle %0d: got %b required %b", c, in_ready, !out_valid || out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
                    errors++;
                    $display("[TB] FAIL rand_hold cycle %0d: valid=%b data=%h tag=%0d required 1 %h %0d",
                             c, out_valid, out_data, out_tag, prev_d, prev_t);
                end
            end
            if (in_valid && in_ready) q.push_back({model(in_data, in_op, int'(in_sa)), in_tag});
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_spurious cycle %0d: data=%h with nothing outstanding", c, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_tag !== e.t) begin
                        errors++;
                        $display("[TB] FAIL rand_result cycle %0d: data=%h tag=%0d required %h %0d",
                                 c, out_data, out_tag, e.d, e.t);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_t = out_tag;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                checks++;
                if (out_data !== e.d || out_tag !== e.t) begin
                    errors++;
                    $display("[TB] FAIL rand_drain: data=%h tag=%0d required %h %0d", out_data, out_tag, e.d, e.t);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_lost: %0d results outstanding required 0", q.size());
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sa = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_arith();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
